sorted_merge8: RTL
==================

Name: sorted_merge8

Overview:
- Consumer-side companion to the 4-element sorter.
- Takes two already-sorted 4-entry lists (A and B), typically the `s0..s3` outputs of two sorter instances once both raise `done`.
- Merges them into one ascending 8-element stream, emitted one element per transfer over a valid/ready handshake.
- Sits between the sorting stage and any downstream serial consumer.

Parameters:
- W, 4, data width of every element (unsigned compare).
- N, 4, entries per input list. Fixed at 4 for this revision; the index counters are sized for it.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  capture `a0..a3`/`b0..b3` and start a merge; honoured only in IDLE or DONE.
- a0,a1,a2,a3  in  W  list A, ascending (`a0` smallest).
- b0,b1,b2,b3  in  W  list B, ascending (`b0` smallest).
- out_valid  out  1  `out_data` holds a valid element.
- out_ready  in  1  downstream accepts the element this cycle.
- out_data  out  W  current merged element.
- out_src  out  1  0 = element came from A, 1 = from B.
- out_last  out  1  current element is the 8th.
- busy  out  1  merge in progress.
- done  out  1  all 8 elements transferred; sticky until the next load or reset.

Behaviour:
- Reset (reset_n = 0, asynchronous, takes effect immediately):
  - state = IDLE; list registers, ia and ib cleared to 0.
  - out_valid, out_last, busy and done = 0; out_data = 0 and out_src = 0.
- Storage: list registers ra[0..3] and rb[0..3]; 3-bit head indices ia and ib (range 0..4).
- States:
  - IDLE, DONE:
    - out_valid = 0, busy = 0; done = 1 in DONE only.
    - load = 1 at a rising edge: capture both lists, set ia = ib = 0, go to MERGE. done drops in the same edge.
  - MERGE:
    - busy = 1, out_valid = 1.
    - Head select is combinational from registers:
      - ia == 4 → take B.
      - ib == 4 → take A.
      - otherwise take A when ra[ia] <= rb[ib], else B. Ties go to A, so the merge is stable.
    - out_data / out_src reflect the selected head.
    - out_last = 1 when ia + ib == 7.
    - Transfer happens when out_valid and out_ready are both 1 at a rising edge; the selected index increments by 1.
    - A transfer with out_last = 1 moves to DONE.
    - load is ignored in MERGE.
- Latency:
  - First element is valid the cycle after load is sampled.
  - With out_ready held at 1, 8 consecutive transfers follow; done is asserted on the 9th cycle after load.
- Handshake:
  - While out_valid = 1 and out_ready = 0, out_data, out_src and out_last hold stable.
  - No element is dropped or duplicated.
  - out_valid never deasserts in MERGE without a transfer.
- Boundaries:
  - One list exhausted (index == 4): the other list drains in order with no further compares.
  - Both indices are never 4 in MERGE.
  - Inputs not sorted: not checked. Output equals the merge rule applied literally; no error flag.
  - reset_n low mid-merge: abort immediately to the reset values above; partial stream discarded.
  - load held high through DONE: a new merge starts on the first edge it is sampled.

Decomposition:
- Shared sort package holds:
  - the element width constant (W = 4) shared with the sorter;
  - the list length constant (N = 4);
  - the state encoding (IDLE, MERGE, DONE).
- One natural sub-module: merge_head_sel, purely combinational. Inputs: two heads plus two exhausted flags. Outputs: selected data and source bit.
- The FSM, index counters and list registers stay in the top module.

Test Plan:
- Interleave: a = 1,3,5,7; b = 2,4,6,8; out_ready = 1 → out_data 1..8 on 8 consecutive cycles; out_src 0,1,0,1,…; out_last with 8; done = 1 the next cycle.
- Ties / stability: a = 2,2,5,9; b = 2,5,5,15 → stream 2,2,2,5,5,5,9,15 with out_src 0,0,1,0,1,1,0,1.
- Exhaustion: a = 0,1,2,3; b = 12,13,14,15 → A fully drains first, then B 12..15 with no compare glitches; reverse the lists and the B-first order is mirrored.
- Backpressure: interleave case with out_ready pattern 1,0,0,1,0,1,1,0,… → out_data stable during stalls; exactly 8 transfers, in order; done only after the 8th.
- Control corner: load pulsed mid-MERGE → ignored, stream unchanged. reset_n low after 3 transfers → out_valid = 0 and busy = 0 immediately; a new load afterwards merges fresh data from index 0.
- Restart: after done, load with a = 15,15,15,15 and b = 0,0,0,0 → 0,0,0,0,15,15,15,15; done clears on the load edge.

Source files
------------

// File: rtl/sorted_merge8_pkg.sv
// Shared constants and state encoding for the sort / merge stages.
package sorted_merge8_pkg;

  localparam int ELEM_W = 4;  // element width, shared with the 4-element sorter
  localparam int LIST_N = 4;  // entries per input list
  localparam int IDX_W  = 3;  // head index width, covers 0..LIST_N

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sorted_merge8_head_sel.sv
// Combinational head selector for the two-list merge. Ties favour A so the
// merge is stable; an exhausted list always yields to the other one.
module merge_head_sel #(
  parameter int W = 4
) (
  input  logic [W-1:0] head_a,
  input  logic [W-1:0] head_b,
  input  logic         a_empty,
  input  logic         b_empty,
  output logic [W-1:0] sel_data,
  output logic         sel_src
);

  // Pick the smaller head, A on ties, skipping the compare once a list is drained.
  always_comb begin
    sel_src = 1'b0;
    if (a_empty)      sel_src = 1'b1;
    else if (b_empty) sel_src = 1'b0;
    else              sel_src = (head_b < head_a);
    sel_data = sel_src ? head_b : head_a;
  end

endmodule

// File: rtl/sorted_merge8.sv
// Merges two ascending 4-entry lists into one ascending 8-element stream,
// one element per valid/ready transfer.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no merge yet; waiting for load
//   ST_MERGE | streaming the selected head; advancing on each transfer
//   ST_DONE  | all 8 elements transferred; done held until next load
module sorted_merge8
  import sorted_merge8_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  input  logic [W-1:0] b2,
  input  logic [W-1:0] b3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_src,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  state_t             state_q, state_d;
  logic [W-1:0]       ra [LIST_N];
  logic [W-1:0]       rb [LIST_N];
  logic [IDX_W-1:0]   ia, ib;
  logic [IDX_W:0]     idx_sum;
  logic               in_merge, is_last, xfer, start;
  logic               a_empty, b_empty;
  logic [W-1:0]       sel_data;
  logic               sel_src;

  assign in_merge = (state_q == ST_MERGE);
  // Index 4 means drained; the low two bits are only used while not drained.
  assign a_empty  = (ia == IDX_W'(LIST_N));
  assign b_empty  = (ib == IDX_W'(LIST_N));
  assign idx_sum  = {1'b0, ia} + {1'b0, ib};
  assign is_last  = (idx_sum == (IDX_W+1)'(2*LIST_N - 1));
  assign xfer     = in_merge && out_ready;
  assign start    = load && !in_merge;

  merge_head_sel #(.W(W)) u_head_sel (
    .head_a   (ra[ia[1:0]]),
    .head_b   (rb[ib[1:0]]),
    .a_empty  (a_empty),
    .b_empty  (b_empty),
    .sel_data (sel_data),
    .sel_src  (sel_src)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: load starts a merge outside MERGE; the last transfer ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (load) state_d = ST_MERGE;
      ST_MERGE:         if (xfer && is_last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // List capture on load and head index advance on each transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LIST_N; i++) begin
        ra[i] <= '0;
        rb[i] <= '0;
      end
      ia <= '0;
      ib <= '0;
    end else if (start) begin
      ra[0] <= a0; ra[1] <= a1; ra[2] <= a2; ra[3] <= a3;
      rb[0] <= b0; rb[1] <= b1; rb[2] <= b2; rb[3] <= b3;
      ia <= '0;
      ib <= '0;
    end else if (xfer) begin
      if (sel_src) ib <= ib + IDX_W'(1);
      else         ia <= ia + IDX_W'(1);
    end
  end

  // Outputs are forced to zero outside MERGE so idle values match reset.
  always_comb begin
    out_valid = in_merge;
    busy      = in_merge;
    done      = (state_q == ST_DONE);
    out_data  = in_merge ? sel_data : '0;
    out_src   = in_merge & sel_src;
    out_last  = in_merge & is_last;
  end

endmodule
